// File: rtl/pipelined_datapath_if.sv
// Issue/result bundle between decode (master) and the pipelined datapath (slave).
interface pipelined_datapath_if #(
  parameter int XLEN = 32,
  parameter int NREG = 32
);
  localparam int AW = $clog2(NREG);

  logic            issue_valid;
  logic            issue_ready;
  logic [AW-1:0]   rs1;
  logic [AW-1:0]   rs2;
  logic [AW-1:0]   rd;
  logic [2:0]      alu_control;
  logic            imm_sel;
  logic [XLEN-1:0] imm;
  logic            wb_en;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_result;
  logic [AW-1:0]   out_rd;
  logic            zero_flag;

  modport master (
    output issue_valid, rs1, rs2, rd, alu_control, imm_sel, imm, wb_en, out_ready,
    input  issue_ready, out_valid, out_result, out_rd, zero_flag
  );

  modport slave (
    input  issue_valid, rs1, rs2, rd, alu_control, imm_sel, imm, wb_en, out_ready,
    output issue_ready, out_valid, out_result, out_rd, zero_flag
  );
endinterface

// File: rtl/pipelined_datapath.sv
// Three-stage (RD/EX/WB) register-file + ALU pipeline with full forwarding and result backpressure.
// Optional shifts (SLL/SRL/SRA on codes 011/100/101) are enabled by defining DATAPATH_SHIFT_OPS_EN.
module pipelined_datapath #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input logic                clk,
  input logic                reset,
  pipelined_datapath_if.slave bus
);
  localparam int AW = $clog2(NREG);
`ifdef DATAPATH_SHIFT_OPS_EN
  localparam int SHW = $clog2(XLEN);
`endif

  logic [XLEN-1:0] r_regfile [NREG];

  logic            r_ex_valid;
  logic [XLEN-1:0] r_ex_a;
  logic [XLEN-1:0] r_ex_b;
  logic [2:0]      r_ex_op;
  logic [AW-1:0]   r_ex_rd;
  logic            r_ex_wb;

  logic            r_wb_valid;
  logic [XLEN-1:0] r_wb_result;
  logic [AW-1:0]   r_wb_rd;
  logic            r_wb_wb;
  logic            r_wb_zero;

  logic            w_stall;
  logic            w_issue_ready;
  logic            w_issue_fire;
  logic            w_retire;
  logic [XLEN-1:0] w_ex_result;
  logic [XLEN-1:0] w_op_a;
  logic [XLEN-1:0] w_op_b;
  logic            w_ex_fwd_en;
  logic            w_wb_fwd_en;

  function automatic logic [XLEN-1:0] alu(
    input logic [2:0]      op,
    input logic [XLEN-1:0] a,
    input logic [XLEN-1:0] b
  );
    logic [XLEN-1:0] res;
    case (op)
      3'b000:  res = a & b;
      3'b001:  res = a | b;
      3'b010:  res = a + b;
      3'b110:  res = a - b;
      3'b111:  res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
`ifdef DATAPATH_SHIFT_OPS_EN
      3'b011:  res = a << b[SHW-1:0];
      3'b100:  res = a >> b[SHW-1:0];
      3'b101:  res = $unsigned($signed(a) >>> b[SHW-1:0]);
`endif
      default: res = {XLEN{1'b0}};
    endcase
    return res;
  endfunction

  // Youngest producer wins: EX result beats the WB result, which beats the file.
  function automatic logic [XLEN-1:0] fwd(
    input logic [AW-1:0]   idx,
    input logic            ex_en,
    input logic [AW-1:0]   ex_rd,
    input logic [XLEN-1:0] ex_res,
    input logic            wb_en,
    input logic [AW-1:0]   wb_rd,
    input logic [XLEN-1:0] wb_res,
    input logic [XLEN-1:0] rf_val
  );
    logic [XLEN-1:0] v;
    if (idx == {AW{1'b0}})            v = {XLEN{1'b0}};
    else if (ex_en && (ex_rd == idx)) v = ex_res;
    else if (wb_en && (wb_rd == idx)) v = wb_res;
    else                              v = rf_val;
    return v;
  endfunction

  assign w_stall       = r_wb_valid && !bus.out_ready;
  assign w_issue_ready = !reset && !w_stall;
  assign w_issue_fire  = bus.issue_valid && w_issue_ready;
  assign w_retire      = r_wb_valid && bus.out_ready;
  assign w_ex_result   = alu(r_ex_op, r_ex_a, r_ex_b);
  assign w_ex_fwd_en   = r_ex_valid && r_ex_wb;
  assign w_wb_fwd_en   = r_wb_valid && r_wb_wb;

  assign bus.issue_ready = w_issue_ready;
  assign bus.out_valid   = r_wb_valid;
  assign bus.out_result  = r_wb_result;
  assign bus.out_rd      = r_wb_rd;
  assign bus.zero_flag   = r_wb_zero;

  // Operand selection at RD, including bypass from EX and WB.
  always_comb begin
    w_op_a = fwd(bus.rs1, w_ex_fwd_en, r_ex_rd, w_ex_result,
                 w_wb_fwd_en, r_wb_rd, r_wb_result, r_regfile[bus.rs1]);
    if (bus.imm_sel) begin
      w_op_b = bus.imm;
    end else begin
      w_op_b = fwd(bus.rs2, w_ex_fwd_en, r_ex_rd, w_ex_result,
                   w_wb_fwd_en, r_wb_rd, r_wb_result, r_regfile[bus.rs2]);
    end
  end

  // Register file: written only when a result actually retires.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) r_regfile[i] <= {XLEN{1'b0}};
    end else if (w_retire && r_wb_wb && (r_wb_rd != {AW{1'b0}})) begin
      r_regfile[r_wb_rd] <= r_wb_result;
    end
  end

  // Pipeline registers; the whole pipe freezes while the result is held back.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ex_valid  <= 1'b0;
      r_ex_a      <= {XLEN{1'b0}};
      r_ex_b      <= {XLEN{1'b0}};
      r_ex_op     <= 3'b000;
      r_ex_rd     <= {AW{1'b0}};
      r_ex_wb     <= 1'b0;
      r_wb_valid  <= 1'b0;
      r_wb_result <= {XLEN{1'b0}};
      r_wb_rd     <= {AW{1'b0}};
      r_wb_wb     <= 1'b0;
      r_wb_zero   <= 1'b0;
    end else if (!w_stall) begin
      r_ex_valid <= w_issue_fire;
      r_wb_valid <= r_ex_valid;
      // Payload only moves with a valid op so bubbles leave the outputs untouched.
      if (w_issue_fire) begin
        r_ex_a  <= w_op_a;
        r_ex_b  <= w_op_b;
        r_ex_op <= bus.alu_control;
        r_ex_rd <= bus.rd;
        r_ex_wb <= bus.wb_en;
      end
      if (r_ex_valid) begin
        r_wb_result <= w_ex_result;
        r_wb_rd     <= r_ex_rd;
        r_wb_wb     <= r_ex_wb;
        r_wb_zero   <= (w_ex_result == {XLEN{1'b0}});
      end
    end
  end
endmodule

// File: tb/tb_pipelined_datapath.sv
// Directed, table-driven bench for pipelined_datapath (XLEN=32, NREG=32).
module tb_pipelined_datapath;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  pipelined_datapath_if #(.XLEN(32), .NREG(32)) bus ();

  pipelined_datapath #(.XLEN(32), .NREG(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  op;
    logic        isel;
    logic [31:0] imm;
    logic        wb;
    logic [31:0] exp;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

`ifdef DATAPATH_SHIFT_OPS_EN
  localparam logic [31:0] E_SRA = 32'hF800_0000;
  localparam logic [31:0] E_SLL = 32'h0000_0002;
  localparam logic [31:0] E_SRL = 32'h0000_0001;
`else
  localparam logic [31:0] E_SRA = 32'h0000_0000;
  localparam logic [31:0] E_SLL = 32'h0000_0000;
  localparam logic [31:0] E_SRL = 32'h0000_0000;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    bus.issue_valid = 1'b1;
    bus.rs1         = v.rs1;
    bus.rs2         = v.rs2;
    bus.rd          = v.rd;
    bus.alu_control = v.op;
    bus.imm_sel     = v.isel;
    bus.imm         = v.imm;
    bus.wb_en       = v.wb;
  endtask

  task automatic idle();
    bus.issue_valid = 1'b0;
  endtask

  task automatic chk_out(input string name, input logic [31:0] res, input logic [4:0] rd);
    chk({name, ".valid"}, {31'd0, bus.out_valid}, 32'd1);
    chk({name, ".result"}, bus.out_result, res);
    chk({name, ".rd"}, {27'd0, bus.out_rd}, {27'd0, rd});
    chk({name, ".zero"}, {31'd0, bus.zero_flag}, {31'd0, (res == 32'd0)});
  endtask

  function automatic vec_t mk(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                              input logic [2:0] op, input logic isel, input logic [31:0] imm,
                              input logic [31:0] exp);
    vec_t v;
    v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.op = op;
    v.isel = isel; v.imm = imm; v.wb = 1'b1; v.exp = exp;
    return v;
  endfunction

  vec_t va, vb, vc, vr;

  initial begin
    n_checks = 0;
    n_errors = 0;
    //             rs1    rs2    rd     op      isel  imm            expected
    vecs[0]  = mk(5'd0,  5'd0,  5'd1,  3'b010, 1'b1, 32'd5,         32'd5);
    vecs[1]  = mk(5'd1,  5'd0,  5'd2,  3'b110, 1'b1, 32'd3,         32'd2);
    vecs[2]  = mk(5'd0,  5'd0,  5'd3,  3'b010, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    vecs[3]  = mk(5'd3,  5'd0,  5'd4,  3'b010, 1'b1, 32'd1,         32'd0);
    vecs[4]  = mk(5'd3,  5'd0,  5'd5,  3'b111, 1'b1, 32'd0,         32'd1);
    vecs[5]  = mk(5'd1,  5'd2,  5'd6,  3'b000, 1'b0, 32'd0,         32'd0);
    vecs[6]  = mk(5'd1,  5'd2,  5'd7,  3'b001, 1'b0, 32'd0,         32'd7);
    vecs[7]  = mk(5'd0,  5'd0,  5'd0,  3'b010, 1'b1, 32'd7,         32'd7);
    vecs[8]  = mk(5'd0,  5'd0,  5'd8,  3'b010, 1'b1, 32'd0,         32'd0);
    vecs[9]  = mk(5'd0,  5'd5,  5'd9,  3'b110, 1'b0, 32'd0,         32'hFFFF_FFFF);
    vecs[10] = mk(5'd9,  5'd6,  5'd10, 3'b111, 1'b0, 32'd0,         32'd1);
    vecs[11] = mk(5'd0,  5'd0,  5'd11, 3'b010, 1'b1, 32'h8000_0000, 32'h8000_0000);
    vecs[12] = mk(5'd11, 5'd0,  5'd12, 3'b101, 1'b1, 32'd4,         E_SRA);
    vecs[13] = mk(5'd10, 5'd0,  5'd13, 3'b011, 1'b1, 32'd33,        E_SLL);
    vecs[14] = mk(5'd11, 5'd0,  5'd14, 3'b100, 1'b1, 32'd31,        E_SRL);
    vecs[15] = mk(5'd7,  5'd0,  5'd15, 3'b010, 1'b1, 32'd0,         32'd7);
    vecs[16] = mk(5'd0,  5'd0,  5'd16, 3'b010, 1'b1, 32'd0,         32'd0);

    reset = 1'b1;
    bus.issue_valid = 1'b0;
    bus.rs1 = 5'd0; bus.rs2 = 5'd0; bus.rd = 5'd0; bus.alu_control = 3'b000;
    bus.imm_sel = 1'b0; bus.imm = 32'd0; bus.wb_en = 1'b0; bus.out_ready = 1'b1;

    tick();
    tick();
    chk("rst.issue_ready", {31'd0, bus.issue_ready}, 32'd0);
    chk("rst.out_valid",   {31'd0, bus.out_valid},   32'd0);
    chk("rst.out_result",  bus.out_result,           32'd0);
    chk("rst.out_rd",      {27'd0, bus.out_rd},      32'd0);
    chk("rst.zero_flag",   {31'd0, bus.zero_flag},   32'd0);
    reset = 1'b0;
    #1;
    chk("idle.issue_ready", {31'd0, bus.issue_ready}, 32'd1);
    tick();
    tick();
    chk("idle.out_valid", {31'd0, bus.out_valid}, 32'd0);

    // Back-to-back stream with out_ready held high; result of vec i-1 visible after edge i.
    for (int i = 0; i < NV + 1; i++) begin
      if (i < NV) drive(vecs[i]);
      else idle();
      tick();
      if (i >= 1) chk_out($sformatf("vec%0d", i - 1), vecs[i - 1].exp, vecs[i - 1].rd);
    end
    idle();
    tick();
    chk("drain.out_valid", {31'd0, bus.out_valid}, 32'd0);

    // Backpressure: three dependent ops, result port blocked.
    va = mk(5'd0,  5'd0, 5'd20, 3'b010, 1'b1, 32'd11, 32'd11);
    vb = mk(5'd20, 5'd0, 5'd21, 3'b010, 1'b1, 32'd1,  32'd12);
    vc = mk(5'd21, 5'd0, 5'd22, 3'b010, 1'b1, 32'd1,  32'd13);
    bus.out_ready = 1'b0;
    drive(va);
    tick();
    drive(vb);
    tick();
    drive(vc);
    #1;
    chk("stall.issue_ready", {31'd0, bus.issue_ready}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_out($sformatf("stall%0d", k), 32'd11, 5'd20);
      chk($sformatf("stall%0d.issue_ready", k), {31'd0, bus.issue_ready}, 32'd0);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("release.issue_ready", {31'd0, bus.issue_ready}, 32'd1);
    tick();
    idle();
    chk_out("rel.B", 32'd12, 5'd21);
    tick();
    chk_out("rel.C", 32'd13, 5'd22);
    tick();
    chk("rel.empty", {31'd0, bus.out_valid}, 32'd0);

    // Read back r22 and r0 from the register file.
    vr = mk(5'd22, 5'd0, 5'd23, 3'b010, 1'b1, 32'd0, 32'd13);
    drive(vr);
    tick();
    vr = mk(5'd0, 5'd0, 5'd24, 3'b010, 1'b1, 32'd0, 32'd0);
    drive(vr);
    tick();
    idle();
    chk_out("rb.r22", 32'd13, 5'd23);
    tick();
    chk_out("rb.r0", 32'd0, 5'd24);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
